// File: rtl/anneal_sched_if.sv
// Control/status bundle for the annealing temperature scheduler.
interface anneal_sched_if #(
  parameter int OUT_W = 4,
  parameter int LT_W  = 4
);
  logic             start;
  logic             abort;
  logic             hold;
  logic [1:0]       mode;
  logic [LT_W-1:0]  log_tau;
  logic [OUT_W-1:0] i_min;
  logic [OUT_W-1:0] i_max;
  logic [OUT_W-1:0] i_0;
  logic             busy;
  logic             done;
  logic             reheat;

  modport master (
    output start, abort, hold, mode, log_tau, i_min, i_max,
    input  i_0, busy, done, reheat
  );

  modport slave (
    input  start, abort, hold, mode, log_tau, i_min, i_max,
    output i_0, busy, done, reheat
  );
endinterface

// File: rtl/anneal_sched.sv
// Annealing temperature scheduler: ramps a fixed-point accumulator from i_min to
// i_max using geometric, linear, staircase or cyclic (sawtooth) profiles.
module anneal_sched #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 4,
  parameter int LT_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  anneal_sched_if.slave bus
);
  localparam int F    = ACC_W - OUT_W;
  localparam int SH_W = $clog2(ACC_W + 1);

  localparam logic [1:0] M_GEO   = 2'd0;
  localparam logic [1:0] M_LIN   = 2'd1;
  localparam logic [1:0] M_STAIR = 2'd2;
  localparam logic [1:0] M_CYC   = 2'd3;

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [SH_W-1:0]  lt;
    logic [OUT_W-1:0] lo;
    logic [OUT_W-1:0] hi;
    logic             flat;   // hi <= lo: nothing to ramp
  } cfg_t;

  state_t           state, state_nx;
  cfg_t             cfg, cfg_nx, cfg_in;
  logic [ACC_W-1:0] acc, acc_nx, step, step_nx, inc, target;
  logic [ACC_W:0]   sum;
  logic [F-1:0]     t, t_nx, tau_m1;
  logic             done_q, done_nx, reheat_q, reheat_nx;
  logic             epoch, hit;

  // Staircase reuses the step register as its fixed one-unit increment.
  function automatic logic [ACC_W-1:0] init_step(cfg_t c);
    logic [ACC_W-1:0] span;
    span = {c.hi - c.lo, {F{1'b0}}};
    case (c.mode)
      M_GEO:   init_step = span >> (c.lt + 1'b1);
      M_STAIR: init_step = ACC_W'(1) << F;
      default: init_step = span >> c.lt;
    endcase
  endfunction

  always_comb begin
    cfg_in.mode = bus.mode;
    cfg_in.lo   = bus.i_min;
    cfg_in.hi   = bus.i_max;
    cfg_in.flat = (bus.i_max <= bus.i_min);
    if (int'(bus.log_tau) > F - 1) cfg_in.lt = SH_W'(F - 1);
    else                           cfg_in.lt = SH_W'(bus.log_tau);
  end

  always_comb begin
    state_nx  = state;
    cfg_nx    = cfg;
    acc_nx    = acc;
    step_nx   = step;
    t_nx      = t;
    done_nx   = 1'b0;
    reheat_nx = 1'b0;

    tau_m1 = (F'(1) << cfg.lt) - F'(1);
    epoch  = (t == tau_m1);
    inc    = (cfg.mode == M_STAIR && !epoch) ? '0 : step;
    target = {cfg.hi, {F{1'b0}}};
    sum    = {1'b0, acc} + {1'b0, inc};
    hit    = (sum >= {1'b0, target});

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nx = RAMP;
          cfg_nx   = cfg_in;
          acc_nx   = {bus.i_min, {F{1'b0}}};
          step_nx  = init_step(cfg_in);
          t_nx     = '0;
        end
      end
      RAMP: begin
        if (bus.hold) begin
          state_nx = RAMP;
        end else if (cfg.flat) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else if (cfg.mode == M_CYC && acc == target) begin
          acc_nx    = {cfg.lo, {F{1'b0}}};
          step_nx   = init_step(cfg);
          t_nx      = '0;
          reheat_nx = 1'b1;
        end else begin
          t_nx   = epoch ? '0 : t + 1'b1;
          acc_nx = hit ? target : sum[ACC_W-1:0];
          if (cfg.mode == M_GEO && epoch)
            step_nx = ((step >> 1) == '0) ? ACC_W'(1) : (step >> 1);
          if (hit && cfg.mode != M_CYC) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort wins over start, hold and completion; the accumulator is left as is.
    if (bus.abort) begin
      state_nx  = IDLE;
      cfg_nx    = cfg;
      acc_nx    = acc;
      step_nx   = step;
      t_nx      = t;
      done_nx   = 1'b0;
      reheat_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cfg      <= '0;
      acc      <= '0;
      step     <= '0;
      t        <= '0;
      done_q   <= 1'b0;
      reheat_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cfg      <= cfg_nx;
      acc      <= acc_nx;
      step     <= step_nx;
      t        <= t_nx;
      done_q   <= done_nx;
      reheat_q <= reheat_nx;
    end
  end

  assign bus.i_0    = acc[ACC_W-1 -: OUT_W];
  assign bus.busy   = (state == RAMP);
  assign bus.done   = done_q;
  assign bus.reheat = reheat_q;
endmodule

// File: tb/tb_anneal_sched.sv
// Directed bench for anneal_sched: per-cycle vector table plus long geometric
// and log_tau-clamp sequences.
module tb_anneal_sched;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  anneal_sched_if #(.OUT_W(4), .LT_W(4)) bus ();

  anneal_sched #(.ACC_W(16), .OUT_W(4), .LT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    bit         rst, start, abort, hold;
    logic [1:0] mode;
    logic [3:0] lt, lo, hi;
    logic [3:0] e_i0;
    bit         e_busy, e_done, e_reheat;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, bit r, bit s, bit a, bit h,
                              logic [1:0] m, logic [3:0] lt, logic [3:0] lo, logic [3:0] hi,
                              logic [3:0] ei, bit eb, bit ed, bit er);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.abort = a; v.hold = h;
    v.mode = m; v.lt = lt; v.lo = lo; v.hi = hi;
    v.e_i0 = ei; v.e_busy = eb; v.e_done = ed; v.e_reheat = er;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit r, bit s, bit a, bit h, logic [1:0] m,
                       logic [3:0] lt, logic [3:0] lo, logic [3:0] hi);
    reset = r; bus.start = s; bus.abort = a; bus.hold = h;
    bus.mode = m; bus.log_tau = lt; bus.i_min = lo; bus.i_max = hi;
  endtask

  initial begin
    logic [3:0] mx;
    int n;
    drive(1, 0, 0, 0, 2'd0, 4'd0, 4'd0, 4'd0);

    // reset, with start asserted to show reset overrides it
    tbl.push_back(mk("rst0", 1,1,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd0,0,0,0));
    tbl.push_back(mk("rst1", 1,0,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd0,0,0,0));
    // linear 4..12, log_tau 3; start on first edge after reset
    tbl.push_back(mk("lin_start", 0,1,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd4,1,0,0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk("lin_ramp", 0,0,0,0, 2'd1,4'd3,4'd4,4'd12, 4'(4+k), k<8, k==8, 0));
    tbl.push_back(mk("lin_after", 0,0,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd12,0,0,0));
    // staircase 0..3, log_tau 2; a start with other config mid-ramp is ignored
    tbl.push_back(mk("stair_start", 0,1,0,0, 2'd2,4'd2,4'd0,4'd3, 4'd0,1,0,0));
    for (int k = 1; k <= 12; k++) begin
      if (k == 2)
        tbl.push_back(mk("stair_restart_ign", 0,1,0,0, 2'd1,4'd0,4'd9,4'd12, 4'(k/4), 1, 0, 0));
      else
        tbl.push_back(mk("stair_ramp", 0,0,0,0, 2'd2,4'd2,4'd0,4'd3, 4'(k/4), k<12, k==12, 0));
    end
    tbl.push_back(mk("stair_after", 0,0,0,0, 2'd2,4'd2,4'd0,4'd3, 4'd3,0,0,0));
    // cyclic 2..5, log_tau 1: step 1.5, sawtooth 2,3,5 then reload
    tbl.push_back(mk("cyc_start", 0,1,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd2,1,0,0));
    tbl.push_back(mk("cyc_a", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd3,1,0,0));
    tbl.push_back(mk("cyc_b", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd5,1,0,0));
    tbl.push_back(mk("cyc_reheat", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd2,1,0,1));
    tbl.push_back(mk("cyc_a2", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd3,1,0,0));
    tbl.push_back(mk("cyc_b2", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd5,1,0,0));
    tbl.push_back(mk("cyc_reheat2", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd2,1,0,1));
    tbl.push_back(mk("cyc_a3", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd3,1,0,0));
    tbl.push_back(mk("cyc_abort_hold", 0,0,1,1, 2'd3,4'd1,4'd2,4'd5, 4'd3,0,0,0));
    tbl.push_back(mk("cyc_idle", 0,0,0,0, 2'd3,4'd1,4'd2,4'd5, 4'd3,0,0,0));
    // abort on the cycle that would complete a linear ramp
    tbl.push_back(mk("abrt_start", 0,1,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd4,1,0,0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk("abrt_ramp", 0,0,0,0, 2'd1,4'd3,4'd4,4'd12, 4'(4+k),1,0,0));
    tbl.push_back(mk("abrt_vs_done", 0,0,1,0, 2'd1,4'd3,4'd4,4'd12, 4'd11,0,0,0));
    tbl.push_back(mk("abrt_idle", 0,0,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd11,0,0,0));
    // hold 7 cycles mid-ramp, then reset mid-RAMP
    tbl.push_back(mk("hold_start", 0,1,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd4,1,0,0));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk("hold_ramp", 0,0,0,0, 2'd1,4'd3,4'd4,4'd12, 4'(4+k),1,0,0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk("hold_frozen", 0,0,0,1, 2'd1,4'd3,4'd4,4'd12, 4'd7,1,0,0));
    tbl.push_back(mk("hold_release", 0,0,0,0, 2'd1,4'd3,4'd4,4'd12, 4'd8,1,0,0));
    tbl.push_back(mk("rst_mid_ramp", 1,1,0,1, 2'd1,4'd3,4'd4,4'd12, 4'd0,0,0,0));
    // i_max == i_min, then i_max < i_min: straight to DONE, acc untouched
    tbl.push_back(mk("flat_start", 0,1,0,0, 2'd1,4'd3,4'd6,4'd6, 4'd6,1,0,0));
    tbl.push_back(mk("flat_done", 0,0,0,0, 2'd1,4'd3,4'd6,4'd6, 4'd6,0,1,0));
    tbl.push_back(mk("flat_after", 0,0,0,0, 2'd1,4'd3,4'd6,4'd6, 4'd6,0,0,0));
    tbl.push_back(mk("inv_start", 0,1,0,0, 2'd0,4'd2,4'd9,4'd3, 4'd9,1,0,0));
    tbl.push_back(mk("inv_done", 0,0,0,0, 2'd0,4'd2,4'd9,4'd3, 4'd9,0,1,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].abort, tbl[i].hold,
            tbl[i].mode, tbl[i].lt, tbl[i].lo, tbl[i].hi);
      @(posedge clk); #1;
      chk($sformatf("%s[%0d] {i_0,busy,done,reheat}", tbl[i].name, i),
          {25'd0, bus.i_0, bus.busy, bus.done, bus.reheat},
          {25'd0, tbl[i].e_i0, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_reheat});
    end

    // geometric 4..12, log_tau 10: step 16 halving per 1024-cycle epoch,
    // clamps at 1 and lands exactly on 12 at cycle 6144
    drive(0, 1, 0, 0, 2'd0, 4'd10, 4'd4, 4'd12);
    @(posedge clk); #1;
    chk("geo_start_i0", {28'd0, bus.i_0}, 32'd4);
    bus.start = 1'b0;
    mx = bus.i_0;
    for (int c = 1; c <= 6144; c++) begin
      @(posedge clk); #1;
      if (bus.i_0 > mx) mx = bus.i_0;
      if (c == 1024) chk("geo_i0_at_1024", {28'd0, bus.i_0}, 32'd8);
      if (c == 2048) chk("geo_i0_at_2048", {28'd0, bus.i_0}, 32'd10);
      if (c == 3072) chk("geo_i0_at_3072", {28'd0, bus.i_0}, 32'd11);
      if (c == 6143) chk("geo_busy_at_6143", {30'd0, bus.busy, bus.done}, 32'b10);
      if (c == 6144) chk("geo_done_at_6144", {27'd0, bus.i_0, bus.done}, {27'd0, 4'd12, 1'b1});
    end
    chk("geo_max_i0", {28'd0, mx}, 32'd12);

    // log_tau 15 clamps to 11: linear 0..1 step 2/4096 takes 2048 cycles
    drive(0, 1, 0, 0, 2'd1, 4'd15, 4'd0, 4'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < 5000);
    chk("lt_clamp_cycles", n, 32'd2048);
    chk("lt_clamp_i0", {28'd0, bus.i_0}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/anneal_sched.md
ANNEAL_SCHED -- requirements
Module: anneal_sched

Interface
REQ-001 Parameter ACC_W, default 16, meaning temperature accumulator width; SHALL be >= OUT_W+2.
REQ-002 Parameter OUT_W, default 4, meaning temperature output width; F = ACC_W-OUT_W fractional bits.
REQ-003 Parameter LT_W, default 4, meaning log_tau width; tau = 2^log_tau cycles per epoch.
REQ-004 clk  input  1  clock; all state SHALL update on posedge clk only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin schedule; sampled only in IDLE or DONE.
REQ-007 abort  input  1  stop schedule; return to IDLE.
REQ-008 hold  input  1  freeze accumulator and epoch counter while high.
REQ-009 mode  input  2  00 geometric, 01 linear, 10 staircase, 11 cyclic; latched at start.
REQ-010 log_tau  input  LT_W  epoch length exponent; latched at start.
REQ-011 i_min, i_max  input  OUT_W each  start and final temperature; latched at start.
REQ-012 i_0  output  OUT_W  current temperature = acc[ACC_W-1 -: OUT_W].
REQ-013 busy  output  1  high in RAMP.
REQ-014 done  output  1  one-cycle pulse on entry to DONE.
REQ-015 reheat  output  1  one-cycle pulse on each cyclic-mode reload.

Function
REQ-016 FSM states SHALL be IDLE, RAMP, DONE.
REQ-017 start high in IDLE/DONE at edge n SHALL latch config, set acc = {i_min, F zeros}, t = 0, enter RAMP; busy=1 from n+1; first increment at edge n+1.
REQ-018 start in RAMP SHALL be ignored.
REQ-019 If latched i_max <= i_min, FSM SHALL go RAMP -> DONE on the first RAMP edge without changing acc.
REQ-020 Effective log_tau lt SHALL be min(log_tau, F-1).
REQ-021 Epoch counter t SHALL count 0..tau-1; epoch event when t == tau-1 (exact period tau cycles), then t = 0.
REQ-022 Geometric: step initialised to (i_max-i_min) << (F-1-lt); halved at each epoch event; never below 1.
REQ-023 Linear and cyclic: step = ((i_max-i_min) << F) >> lt, constant.
REQ-024 Staircase: acc += 2^F only at epoch events; no change on other cycles.
REQ-025 Target M = {i_max, F zeros}; if acc+step >= M (computed ACC_W+1 bits, no wrap) acc SHALL load M exactly; never overshoot.
REQ-026 Modes 00-10: the edge that makes acc == M SHALL also enter DONE; done pulses next cycle; i_0 holds i_max.
REQ-027 Cyclic: edge after acc == M SHALL reload acc = {i_min, F zeros}, reset step and t, pulse reheat; never enters DONE.
REQ-028 hold high in RAMP SHALL freeze acc, step, t; FSM stays RAMP; hold ignored outside RAMP.
REQ-029 abort high SHALL enter IDLE next edge, keep acc (i_0 frozen), busy=0, no done pulse; abort takes priority over hold and completion in same cycle.
REQ-030 In IDLE and DONE acc SHALL remain unchanged.

Reset
REQ-031 reset SHALL force IDLE, acc=0, step=0, t=0, i_0=0, busy=0, done=0, reheat=0; overrides all inputs including mid-RAMP.
REQ-032 First edge after reset deasserts SHALL honour start.

Verification (ACC_W=16, OUT_W=4, F=12)
REQ-033 Linear, i_min=4, i_max=12, log_tau=3: i_0 = 4,5,...,12 one per cycle, done pulses exactly once, busy low after.
REQ-034 Geometric, i_min=4, i_max=12, log_tau=10: step0=16; i_0=8 after 1024 RAMP cycles, 10 after 2048; step never reaches 0; i_0 never exceeds 12.
REQ-035 Staircase, i_min=0, i_max=3, log_tau=2: i_0 steps 0->1->2->3 every 4 cycles; done after 12 RAMP cycles.
REQ-036 Cyclic, i_min=2, i_max=5, log_tau=1: i_0 sawtooth 2..5, reheat pulse every period; abort -> IDLE, i_0 frozen.
REQ-037 Linear run with hold high for 7 cycles mid-ramp then reset mid-RAMP: i_0 constant during hold, all outputs 0 after reset; i_max=i_min start -> done with no acc change.
